// File: rtl/washer_drum_model.sv
// Synthesizable plant model of a washing-machine drum: water level/temperature, door latch, soap drawer,
// spin-up and sticky safety faults. Define WASHER_DRUM_LEAK_EN to add the leak_inject input.
module washer_drum_model #(
  parameter int LEVEL_W        = 8,
  parameter int FILL_RATE      = 4,
  parameter int DRAIN_RATE     = 6,
  parameter int LEVEL_MAX      = 200,
  parameter int FULL_LEVEL     = 160,
  parameter int COLD_TEMP      = 15,
  parameter int HOT_TEMP       = 60,
  parameter int AMBIENT        = 20,
  parameter int SOAP_DISPENSE  = 3,
  parameter int UNLOCK_DELAY   = 4,
  parameter int SPIN_UP_CYCLES = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valve_in_cold,
  input  logic               valve_in_hot,
  input  logic               valve_out,
  input  logic [1:0]         motor,
  input  logic               lockDoor,
  input  logic               soap_in,
  input  logic               door_close_req,
  input  logic               door_open_req,
  input  logic               soap_load,
`ifdef WASHER_DRUM_LEAK_EN
  input  logic               leak_inject,
`endif
  output logic               doorclosed,
  output logic               door_locked,
  output logic               soap,
  output logic [LEVEL_W-1:0] water_level,
  output logic               water_full,
  output logic               water_empty,
  output logic [LEVEL_W-1:0] water_temp,
  output logic               spin_ready,
  output logic               overflow_fault,
  output logic               dry_wash_fault,
  output logic               door_fault
);

  typedef logic signed [LEVEL_W+1:0] level_s_t;
  typedef logic        [LEVEL_W-1:0] level_t;

  localparam level_s_t FILL_S      = level_s_t'(FILL_RATE);
  localparam level_s_t DRAIN_S     = level_s_t'(DRAIN_RATE);
  localparam level_s_t LEVEL_MAX_S = level_s_t'(LEVEL_MAX);
  localparam level_t   LEVEL_MAX_U = level_t'(LEVEL_MAX);
  localparam level_t   FULL_U      = level_t'(FULL_LEVEL);
  localparam level_t   COLD_T      = level_t'(COLD_TEMP);
  localparam level_t   HOT_T       = level_t'(HOT_TEMP);
  localparam level_t   MIX_T       = level_t'((COLD_TEMP + HOT_TEMP) >> 1);
  localparam level_t   AMBIENT_T   = level_t'(AMBIENT);

  localparam int UCW = $clog2(UNLOCK_DELAY + 1);
  localparam int SCW = $clog2(SOAP_DISPENSE + 1);
  localparam int PCW = $clog2(SPIN_UP_CYCLES + 1);

  localparam logic [UCW-1:0] UNLOCK_LOAD = UCW'(UNLOCK_DELAY);
  localparam logic [SCW-1:0] SOAP_LAST   = SCW'(SOAP_DISPENSE - 1);
  localparam logic [PCW-1:0] SPIN_SAT    = PCW'(SPIN_UP_CYCLES);

  typedef enum logic [1:0] {
    ST_OPEN,
    ST_CLOSED,
    ST_LOCKED,
    ST_UNLOCK_WAIT
  } door_state_e;

  door_state_e    state_q, state_d;
  logic [UCW-1:0] unlock_cnt;
  logic [SCW-1:0] soap_cnt;
  logic [PCW-1:0] spin_cnt;

  level_s_t level_raw;
  level_t   level_next;
  logic     level_over;
  level_t   temp_target;
  level_t   temp_next;
  logic     inflow;

  assign inflow = valve_in_cold | valve_in_hot;

  // ---------------------------------------------------------------------------
  // Water level: signed headroom so a drain below zero and a fill above the
  // ceiling are both visible before clamping.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    level_raw = level_s_t'({2'b00, water_level});
    if (valve_in_cold) level_raw = level_raw + FILL_S;
    if (valve_in_hot)  level_raw = level_raw + FILL_S;
    if (valve_out)     level_raw = level_raw - DRAIN_S;
`ifdef WASHER_DRUM_LEAK_EN
    if (leak_inject)   level_raw = level_raw - level_s_t'(1);
`endif
    level_over = 1'b0;
    if (level_raw[LEVEL_W+1]) begin
      level_next = '0;
    end else if (level_raw > LEVEL_MAX_S) begin
      level_next = LEVEL_MAX_U;
      level_over = 1'b1;
    end else begin
      level_next = level_raw[LEVEL_W-1:0];
    end
  end

  assign water_full  = (water_level >= FULL_U);
  assign water_empty = (water_level == '0);

  // Temperature: an empty drum snaps to ambient, otherwise inflow nudges it one unit toward the inlet mix.
  always_comb begin
    case ({valve_in_cold, valve_in_hot})
      2'b10:   temp_target = COLD_T;
      2'b01:   temp_target = HOT_T;
      default: temp_target = MIX_T;
    endcase
    temp_next = water_temp;
    if (water_empty) begin
      temp_next = AMBIENT_T;
    end else if (inflow) begin
      if (water_temp < temp_target)      temp_next = water_temp + 1'b1;
      else if (water_temp > temp_target) temp_next = water_temp - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      water_level <= '0;
      water_temp  <= AMBIENT_T;
    end else begin
      water_level <= level_next;
      water_temp  <= temp_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Door latch FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_OPEN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OPEN:        if (door_close_req) state_d = ST_CLOSED;
      ST_CLOSED: begin
        if (lockDoor)           state_d = ST_LOCKED;
        else if (door_open_req) state_d = ST_OPEN;
      end
      ST_LOCKED:      if (!lockDoor) state_d = ST_UNLOCK_WAIT;
      ST_UNLOCK_WAIT: begin
        if (lockDoor)                                  state_d = ST_LOCKED;
        else if ((unlock_cnt == '0) && water_empty)    state_d = ST_CLOSED;
      end
      default:        state_d = ST_OPEN;
    endcase
  end

  always_comb begin
    doorclosed  = (state_q != ST_OPEN);
    door_locked = (state_q == ST_LOCKED) || (state_q == ST_UNLOCK_WAIT);
  end

  // The latch keeps holding for a minimum time and, beyond that, until the drum has drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      unlock_cnt <= '0;
    end else if ((state_q == ST_LOCKED) && !lockDoor) begin
      unlock_cnt <= UNLOCK_LOAD;
    end else if ((state_q == ST_UNLOCK_WAIT) && (unlock_cnt != '0)) begin
      unlock_cnt <= unlock_cnt - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Soap drawer: a fresh load always wins over an in-progress dispense.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      soap     <= 1'b0;
      soap_cnt <= '0;
    end else if (soap_load) begin
      soap     <= 1'b1;
      soap_cnt <= '0;
    end else if (soap_in && soap) begin
      if (soap_cnt == SOAP_LAST) begin
        soap     <= 1'b0;
        soap_cnt <= '0;
      end else begin
        soap_cnt <= soap_cnt + 1'b1;
      end
    end else begin
      soap_cnt <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Spin-up: consecutive spin commands, saturating at the ready count.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst)                 spin_cnt <= '0;
    else if (motor != 2'd2)  spin_cnt <= '0;
    else if (spin_cnt != SPIN_SAT) spin_cnt <= spin_cnt + 1'b1;
  end

  assign spin_ready = (spin_cnt == SPIN_SAT);

  // ---------------------------------------------------------------------------
  // Sticky safety faults; motor code 3 counts as stop.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_fault <= 1'b0;
      dry_wash_fault <= 1'b0;
      door_fault     <= 1'b0;
    end else begin
      if (level_over) overflow_fault <= 1'b1;
      if ((motor == 2'd1) && water_empty) dry_wash_fault <= 1'b1;
      if (!door_locked && ((motor == 2'd1) || (motor == 2'd2) || inflow || valve_out))
        door_fault <= 1'b1;
    end
  end

endmodule
